// File: rtl/ahb_sram_ctrl_pkg.sv
// ahb_sram_ctrl_pkg: shared encodings, FSM state type and byte-lane helper for the
// AHB-Lite SRAM slave.
package ahb_sram_ctrl_pkg;

   typedef enum logic [1:0] {
      HtransIdle   = 2'b00,
      HtransBusy   = 2'b01,
      HtransNonseq = 2'b10,
      HtransSeq    = 2'b11
   } htrans_e;

   typedef enum logic [2:0] {
      HsizeByte   = 3'd0,
      HsizeHalf   = 3'd1,
      HsizeWord   = 3'd2,
      HsizeDword  = 3'd3,
      Hsize4Word  = 3'd4,
      Hsize8Word  = 3'd5,
      Hsize16Word = 3'd6,
      Hsize32Word = 3'd7
   } hsize_e;

   typedef enum logic [2:0] {
      StIdle,
      StWait,
      StDone,
      StErr1,
      StErr2
   } state_e;

   // Widest supported bus is 1024 bits, i.e. 128 byte lanes
   localparam int unsigned MaxBytes = 128;

   // Lanes touched by a 2^size-byte transfer at byte offset, clipped to the bus width
   function automatic logic [MaxBytes-1:0] lane_mask(input logic [2:0]  size,
                                                     input logic [6:0]  offset,
                                                     input int unsigned bytes);
      logic [MaxBytes-1:0] m;
      m = '0;
      for (int unsigned i = 0; i < MaxBytes; i++) begin
         if (i < (32'd1 << size)) m[i] = 1'b1;
      end
      m = m << offset;
      for (int unsigned i = 0; i < MaxBytes; i++) begin
         if (i >= bytes) m[i] = 1'b0;
      end
      return m;
   endfunction

endpackage

// File: rtl/ahb_sram_ctrl_excl_mon.sv
// ahb_sram_ctrl_excl_mon: single-entry exclusive-access monitor {valid, master, word index}.
// Only instantiated when AHB_SRAM_CTRL_EXCL_EN is defined.
module ahb_sram_ctrl_excl_mon
   import ahb_sram_ctrl_pkg::*;
#(
   parameter int unsigned IDX_WIDTH     = 10,
   parameter int unsigned HMASTER_WIDTH = 4
) (
   input  logic                     hclk,
   input  logic                     hresetn,
   input  logic                     i_set,       // final cycle of an OKAY exclusive read
   input  logic                     i_excl_wr,   // final cycle of an exclusive write
   input  logic                     i_plain_wr,  // committed non-exclusive write
   input  logic [HMASTER_WIDTH-1:0] i_master,
   input  logic [IDX_WIDTH-1:0]     i_idx,
   output logic                     o_match
);

   logic                     r_valid;
   logic [HMASTER_WIDTH-1:0] r_master;
   logic [IDX_WIDTH-1:0]     r_idx;
   logic                     w_idx_hit;

   assign w_idx_hit = r_valid & (r_idx == i_idx);
   assign o_match   = w_idx_hit & (r_master == i_master);

   // Arm on exclusive read; drop on successful exclusive write or any plain write to the index
   always_ff @(posedge hclk or negedge hresetn) begin
      if (!hresetn) begin
         r_valid  <= 1'b0;
         r_master <= '0;
         r_idx    <= '0;
      end else if (i_set) begin
         r_valid  <= 1'b1;
         r_master <= i_master;
         r_idx    <= i_idx;
      end else if (i_excl_wr && o_match) begin
         r_valid  <= 1'b0;
      end else if (i_plain_wr && w_idx_hit) begin
         r_valid  <= 1'b0;
      end
   end

endmodule

// File: rtl/ahb_sram_ctrl.sv
// ahb_sram_ctrl: AHB-Lite SRAM slave with programmable wait states, byte-lane writes,
// two-cycle ERROR responses and an internal memory array.
// Build option: define AHB_SRAM_CTRL_EXCL_EN to add the single-entry exclusive monitor.
module ahb_sram_ctrl
   import ahb_sram_ctrl_pkg::*;
#(
   parameter int unsigned HADDR_WIDTH   = 32,
   parameter int unsigned DATA_WIDTH    = 32,
   parameter int unsigned MEM_DEPTH     = 1024,
   parameter int unsigned WAIT_STATES   = 0,
   parameter int unsigned HMASTER_WIDTH = 4
) (
   input  logic                      hclk,
   input  logic                      hresetn,
   input  logic                      hsel,
   input  logic                      hready,
   input  logic [HADDR_WIDTH-1:0]    haddr,
   input  logic [1:0]                htrans,
   input  logic                      hwrite,
   input  logic [2:0]                hsize,
   input  logic [HMASTER_WIDTH-1:0]  hmaster,
   input  logic                      hexcl,
   input  logic [DATA_WIDTH-1:0]     hwdata,
   input  logic [DATA_WIDTH/8-1:0]   hwstrb,
   output logic [DATA_WIDTH-1:0]     hrdata,
   output logic                      hreadyout,
   output logic                      hresp,
   output logic                      hexokay
);

   localparam int unsigned Bytes    = DATA_WIDTH / 8;
   localparam int unsigned OffW     = $clog2(Bytes);
   localparam int unsigned IdxW     = $clog2(MEM_DEPTH);
   localparam logic [2:0]  WaitLoad = (WAIT_STATES == 0) ? 3'd0 : 3'(WAIT_STATES - 1);

   state_e                 r_state, w_state_nxt;
   logic [2:0]             r_cnt, w_cnt_nxt;
   logic                   r_pend, w_pend_nxt;
   logic [IdxW-1:0]        r_idx;
   logic [OffW-1:0]        r_off;
   logic [2:0]             r_size;
   logic                   r_write;
   logic [DATA_WIDTH-1:0]  r_rdata;
   logic [DATA_WIDTH-1:0]  r_mem [MEM_DEPTH];

   logic                   w_ready, w_take, w_err, w_oor, w_size_err, w_misalign;
   logic [HADDR_WIDTH-1:0] w_word_full;
   logic [7:0]             w_amask;
   logic                   w_final, w_rd_final, w_wr_en, w_excl_fail;
   logic [Bytes-1:0]       w_lanes;

   // Address-phase decode and error classification
   assign w_word_full = haddr >> OffW;
   assign w_oor       = 64'(w_word_full) >= 64'(MEM_DEPTH);
   assign w_size_err  = 32'(hsize) > OffW;
   assign w_amask     = 8'((16'd1 << hsize) - 16'd1);
   assign w_misalign  = |(haddr[7:0] & w_amask);
   assign w_err       = w_oor | w_size_err | w_misalign;

   assign w_ready   = ~((r_state == StWait) || (r_state == StErr1));
   assign w_take    = hsel & hready & htrans[1] & w_ready;
   assign hreadyout = w_ready;
   assign hresp     = (r_state == StErr1) || (r_state == StErr2);

   // Zero-wait data phases stay in StIdle and are tracked by r_pend instead
   assign w_final    = (r_state == StDone) | ((r_state == StIdle) & r_pend);
   assign w_rd_final = w_final & ~r_write;
   assign w_wr_en    = w_final & r_write & ~w_excl_fail;
   assign w_lanes    = Bytes'(lane_mask(r_size, 7'(r_off), Bytes)) & hwstrb;

   // Final read cycle sees the array directly so a write committed one edge earlier is visible
   assign hrdata = w_rd_final ? r_mem[r_idx] : r_rdata;

   // Next-state and wait-counter logic
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_pend_nxt  = 1'b0;
      unique case (r_state)
         StWait: begin
            if (r_cnt == 3'd0) w_state_nxt = StDone;
            else               w_cnt_nxt   = r_cnt - 3'd1;
         end
         StErr1:  w_state_nxt = StErr2;
         default: w_state_nxt = StIdle;
      endcase
      if (w_take) begin
         if (w_err) begin
            w_state_nxt = StErr1;
         end else if (WAIT_STATES == 0) begin
            w_state_nxt = StIdle;
            w_pend_nxt  = 1'b1;
         end else begin
            w_state_nxt = StWait;
            w_cnt_nxt   = WaitLoad;
         end
      end
   end

   // FSM state, wait counter and zero-wait pending flag
   always_ff @(posedge hclk or negedge hresetn) begin
      if (!hresetn) begin
         r_state <= StIdle;
         r_cnt   <= 3'd0;
         r_pend  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_pend  <= w_pend_nxt;
      end
   end

   // Address-phase capture on acceptance
   always_ff @(posedge hclk or negedge hresetn) begin
      if (!hresetn) begin
         r_idx   <= '0;
         r_off   <= '0;
         r_size  <= 3'd0;
         r_write <= 1'b0;
      end else if (w_take) begin
         r_idx   <= haddr[OffW +: IdxW];
         r_off   <= haddr[OffW-1:0];
         r_size  <= hsize;
         r_write <= hwrite;
      end
   end

   // Hold the last read word between read data phases
   always_ff @(posedge hclk or negedge hresetn) begin
      if (!hresetn)        r_rdata <= '0;
      else if (w_rd_final) r_rdata <= r_mem[r_idx];
   end

   // Byte-lane write commit at the end of the final data-phase cycle
   always_ff @(posedge hclk) begin
      if (w_wr_en) begin
         for (int unsigned b = 0; b < Bytes; b++) begin
            if (w_lanes[b]) r_mem[r_idx][8*b +: 8] <= hwdata[8*b +: 8];
         end
      end
   end

`ifdef AHB_SRAM_CTRL_EXCL_EN
   logic [HMASTER_WIDTH-1:0] r_master;
   logic                     r_excl;
   logic                     w_match;
   logic                     w_unused;

   // Master ID and exclusive flag captured with the address phase
   always_ff @(posedge hclk or negedge hresetn) begin
      if (!hresetn) begin
         r_master <= '0;
         r_excl   <= 1'b0;
      end else if (w_take) begin
         r_master <= hmaster;
         r_excl   <= hexcl;
      end
   end

   ahb_sram_ctrl_excl_mon #(
      .IDX_WIDTH     (IdxW),
      .HMASTER_WIDTH (HMASTER_WIDTH)
   ) u_excl_mon (
      .hclk       (hclk),
      .hresetn    (hresetn),
      .i_set      (w_final & r_excl & ~r_write),
      .i_excl_wr  (w_final & r_excl & r_write),
      .i_plain_wr (w_wr_en & ~r_excl),
      .i_master   (r_master),
      .i_idx      (r_idx),
      .o_match    (w_match)
   );

   // A failed exclusive write completes OKAY but leaves memory untouched
   assign w_excl_fail = r_excl & r_write & ~w_match;
   assign hexokay     = w_final & r_excl & (~r_write | w_match);
   assign w_unused    = htrans[0];
`else
   logic w_unused;

   assign w_excl_fail = 1'b0;
   assign hexokay     = 1'b0;
   assign w_unused    = ^{htrans[0], hexcl, hmaster};
`endif

endmodule

// File: tb/tb_ahb_sram_ctrl.sv
// tb_ahb_sram_ctrl: table-driven bench for ahb_sram_ctrl with a pipelined AHB driver and an
// in-order scoreboard. Two instances: zero-wait (u_dut0) and three wait states (u_dut3).
module tb_ahb_sram_ctrl;

   typedef struct {
      bit          wr;
      logic [31:0] addr;
      logic [2:0]  size;
      logic [31:0] wdata;
      logic [3:0]  strb;
      logic [3:0]  master;
      bit          excl;
      int          gap;
      bit          e_resp;
      bit          e_chk;
      logic [31:0] e_rdata;
      bit          e_exokay;
   } vec_t;

   logic        hclk = 1'b0;
   logic        hresetn;
   logic        hsel;
   logic [31:0] haddr;
   logic [1:0]  htrans;
   logic        hwrite;
   logic [2:0]  hsize;
   logic [3:0]  hmaster;
   logic        hexcl;
   logic [31:0] hwdata;
   logic [3:0]  hwstrb;
   bit          sel;

   logic [31:0] rd0, rd3;
   logic        ro0, ro3, rs0, rs3, ex0, ex3;
   logic [31:0] hrdata_m;
   logic        hready_m, hresp_m, hexokay_m;

   int   n_vec = 0;
   int   n_err = 0;
   vec_t q[$];
   vec_t sb[$];
   vec_t tbl[22];

   always #5 hclk = ~hclk;

   assign hrdata_m  = sel ? rd3 : rd0;
   assign hready_m  = sel ? ro3 : ro0;
   assign hresp_m   = sel ? rs3 : rs0;
   assign hexokay_m = sel ? ex3 : ex0;

   ahb_sram_ctrl #(.WAIT_STATES(0)) u_dut0 (
      .hclk(hclk), .hresetn(hresetn), .hsel(hsel & ~sel), .hready(ro0), .haddr(haddr),
      .htrans(htrans), .hwrite(hwrite), .hsize(hsize), .hmaster(hmaster), .hexcl(hexcl),
      .hwdata(hwdata), .hwstrb(hwstrb), .hrdata(rd0), .hreadyout(ro0), .hresp(rs0),
      .hexokay(ex0)
   );

   ahb_sram_ctrl #(.WAIT_STATES(3)) u_dut3 (
      .hclk(hclk), .hresetn(hresetn), .hsel(hsel & sel), .hready(ro3), .haddr(haddr),
      .htrans(htrans), .hwrite(hwrite), .hsize(hsize), .hmaster(hmaster), .hexcl(hexcl),
      .hwdata(hwdata), .hwstrb(hwstrb), .hrdata(rd3), .hreadyout(ro3), .hresp(rs3),
      .hexokay(ex3)
   );

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, got running, expected done");
      $fatal(1);
   end

   function automatic vec_t mkx(bit wr, logic [31:0] addr, logic [2:0] size, logic [31:0] wdata,
                                logic [3:0] strb, logic [3:0] master, bit excl, int gap,
                                bit e_resp, bit e_chk, logic [31:0] e_rdata, bit e_exokay);
      vec_t v;
      v.wr = wr; v.addr = addr; v.size = size; v.wdata = wdata; v.strb = strb;
      v.master = master; v.excl = excl; v.gap = gap; v.e_resp = e_resp; v.e_chk = e_chk;
      v.e_rdata = e_rdata; v.e_exokay = e_exokay;
      return v;
   endfunction

   function automatic vec_t wr_v(logic [31:0] addr, logic [2:0] size, logic [31:0] wdata,
                                 logic [3:0] strb, bit e_resp);
      return mkx(1'b1, addr, size, wdata, strb, 4'd0, 1'b0, 0, e_resp, 1'b0, 32'h0, 1'b0);
   endfunction

   function automatic vec_t rd_v(logic [31:0] addr, logic [2:0] size, bit e_resp,
                                 logic [31:0] e_rdata, int gap);
      return mkx(1'b0, addr, size, 32'h0, 4'h0, 4'd0, 1'b0, gap, e_resp, ~e_resp, e_rdata, 1'b0);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic drive_addr(input vec_t v);
      hsel = 1'b1; htrans = 2'b10; haddr = v.addr; hwrite = v.wr; hsize = v.size;
      hmaster = v.master; hexcl = v.excl;
   endtask

   // No-transfer cycles alternate between BUSY with hsel=1 and NONSEQ with hsel=0
   task automatic drive_idle();
      hsel    = 1'($urandom_range(0, 1));
      htrans  = hsel ? 2'b01 : 2'b10;
      haddr   = $urandom & 32'h0000_0FFC;
      hwrite  = 1'($urandom_range(0, 1));
      hsize   = 3'd2;
      hmaster = 4'd0;
      hexcl   = 1'b0;
   endtask

   // Pipelined driver: address phase of the next item overlaps the data phase of the current
   task automatic run_q(input string tag);
      vec_t        a;
      bit          have_a = 0, have_d = 0;
      int          gapc = 0, lat = 0, cyc = 0, idx = 0;
      logic        rdy;
      int unsigned ws;
      ws = sel ? 3 : 0;
      while (q.size() > 0 || have_a || have_d) begin
         if (!have_a && q.size() > 0) begin
            a = q.pop_front(); have_a = 1; gapc = a.gap;
         end
         if (have_a && gapc == 0) drive_addr(a);
         else                     drive_idle();
         @(negedge hclk);
         rdy = hready_m;
         if (have_d) begin
            lat++;
            if (!rdy) begin
               chk($sformatf("%s[%0d] wait-cycle rdy/resp/exokay", tag, idx),
                   32'({hready_m, hresp_m, hexokay_m}), 32'({1'b0, sb[0].e_resp, 1'b0}));
            end else begin
               vec_t d;
               d = sb.pop_front();
               chk($sformatf("%s[%0d] hresp", tag, idx), 32'(hresp_m), 32'(d.e_resp));
               chk($sformatf("%s[%0d] latency", tag, idx), 32'(lat),
                   d.e_resp ? 32'd2 : 32'(1 + ws));
               chk($sformatf("%s[%0d] hexokay", tag, idx), 32'(hexokay_m), 32'(d.e_exokay));
               if (d.e_chk) chk($sformatf("%s[%0d] hrdata", tag, idx), hrdata_m, d.e_rdata);
               have_d = 0;
               idx++;
            end
         end else begin
            chk($sformatf("%s idle rdy/resp/exokay", tag),
                32'({hready_m, hresp_m, hexokay_m}), 32'(3'b100));
         end
         @(posedge hclk);
         #1;
         if (rdy && have_a) begin
            if (gapc == 0) begin
               sb.push_back(a);
               hwdata = a.wdata; hwstrb = a.strb;
               have_d = 1; have_a = 0; lat = 0;
            end else begin
               gapc--;
            end
         end
         cyc++;
         if (cyc > 2000) begin
            n_vec++; n_err++;
            $display("FAIL %s timeout: got %0d cycles, expected completion", tag, cyc);
            q.delete(); sb.delete();
            break;
         end
      end
      drive_idle();
   endtask

   initial begin
      // Zero-wait table: applied back-to-back, so every read right after a write is RAW
      tbl[0]  = wr_v(32'h10, 3'd2, 32'hDEADBEEF, 4'hF, 1'b0);
      tbl[1]  = rd_v(32'h10, 3'd2, 1'b0, 32'hDEADBEEF, 0);
      tbl[2]  = wr_v(32'h20, 3'd2, 32'h11223344, 4'hF, 1'b0);
      tbl[3]  = wr_v(32'h21, 3'd0, 32'h0000AA00, 4'hF, 1'b0);
      tbl[4]  = rd_v(32'h20, 3'd2, 1'b0, 32'h1122AA44, 1);
      tbl[5]  = rd_v(32'h1000, 3'd2, 1'b1, 32'h0, 0);
      tbl[6]  = wr_v(32'h22, 3'd2, 32'hCAFEF00D, 4'hF, 1'b1);
      tbl[7]  = rd_v(32'h20, 3'd2, 1'b0, 32'h1122AA44, 0);
      tbl[8]  = wr_v(32'h22, 3'd1, 32'h55660000, 4'hF, 1'b0);
      tbl[9]  = rd_v(32'h20, 3'd2, 1'b0, 32'h5566AA44, 0);
      tbl[10] = wr_v(32'h24, 3'd2, 32'h01020304, 4'hF, 1'b0);
      tbl[11] = wr_v(32'h24, 3'd2, 32'hFFFFFFFF, 4'h5, 1'b0);
      tbl[12] = wr_v(32'h25, 3'd0, 32'h0000BB00, 4'hD, 1'b0);
      tbl[13] = rd_v(32'h27, 3'd0, 1'b0, 32'h01FF03FF, 0);
      tbl[14] = wr_v(32'h28, 3'd3, 32'h12345678, 4'hF, 1'b1);
      tbl[15] = wr_v(32'hFFC, 3'd2, 32'hA5A5A5A5, 4'hF, 1'b0);
      tbl[16] = rd_v(32'hFFC, 3'd2, 1'b0, 32'hA5A5A5A5, 2);
      tbl[17] = rd_v(32'h8000_0010, 3'd2, 1'b1, 32'h0, 0);
      tbl[18] = rd_v(32'h10, 3'd2, 1'b0, 32'hDEADBEEF, 0);
      tbl[19] = wr_v(32'h0, 3'd2, 32'h600DCAFE, 4'hF, 1'b0);
      tbl[20] = wr_v(32'h1000, 3'd2, 32'hBAD0BAD0, 4'hF, 1'b1);
      tbl[21] = rd_v(32'h0, 3'd2, 1'b0, 32'h600DCAFE, 0);

      sel = 1'b0; hwdata = '0; hwstrb = '0; hresetn = 1'b0;
      drive_idle();
      repeat (2) @(posedge hclk);
      #1;
      chk("reset hrdata0", rd0, 32'h0);
      chk("reset rdy/resp/exokay0", 32'({ro0, rs0, ex0}), 32'(3'b100));
      chk("reset hrdata3", rd3, 32'h0);
      chk("reset rdy/resp/exokay3", 32'({ro3, rs3, ex3}), 32'(3'b100));
      @(posedge hclk);
      #1 hresetn = 1'b1;

      for (int i = 0; i < 22; i++) q.push_back(tbl[i]);
      run_q("tbl");
      q.push_back(rd_v(32'h21, 3'd1, 1'b1, 32'h0, 0));
      q.push_back(rd_v(32'h20, 3'd2, 1'b0, 32'h5566AA44, 0));
      run_q("half_misalign");

      // Three wait states, back-to-back reads, and an error that stays two cycles
      sel = 1'b1;
      q.push_back(wr_v(32'h10, 3'd2, 32'h12345678, 4'hF, 1'b0));
      q.push_back(rd_v(32'h10, 3'd2, 1'b0, 32'h12345678, 0));
      q.push_back(rd_v(32'h10, 3'd2, 1'b0, 32'h12345678, 0));
      q.push_back(rd_v(32'h1000, 3'd2, 1'b1, 32'h0, 0));
      q.push_back(wr_v(32'h14, 3'd2, 32'h0, 4'hF, 1'b0));
      q.push_back(wr_v(32'h17, 3'd0, 32'hAB000000, 4'hF, 1'b0));
      q.push_back(rd_v(32'h14, 3'd2, 1'b0, 32'hAB000000, 0));
      run_q("ws3");

      // Reset in the middle of a waited write: no commit, outputs drop to reset values at once
      q.push_back(wr_v(32'h40, 3'd2, 32'h0BADF00D, 4'hF, 1'b0));
      q.push_back(rd_v(32'h40, 3'd2, 1'b0, 32'h0BADF00D, 0));
      run_q("pre_abort");
      drive_addr(wr_v(32'h40, 3'd2, 32'h0, 4'hF, 1'b0));
      @(posedge hclk);
      #1;
      hwdata = 32'hFFFFFFFF; hwstrb = 4'hF;
      drive_idle();
      @(negedge hclk);
      chk("abort wait hreadyout", 32'(hready_m), 32'h0);
      chk("abort held hrdata", hrdata_m, 32'h0BADF00D);
      hresetn = 1'b0;
      #1;
      chk("abort async rdy/resp/exokay", 32'({hready_m, hresp_m, hexokay_m}), 32'(3'b100));
      chk("abort async hrdata", hrdata_m, 32'h0);
      @(posedge hclk);
      @(posedge hclk);
      #1 hresetn = 1'b1;
      q.push_back(rd_v(32'h40, 3'd2, 1'b0, 32'h0BADF00D, 0));
      run_q("post_abort");

      // Exclusive access on the zero-wait instance
      sel = 1'b0;
      q.push_back(wr_v(32'h40, 3'd2, 32'h11111111, 4'hF, 1'b0));
`ifdef AHB_SRAM_CTRL_EXCL_EN
      q.push_back(mkx(0, 32'h40, 3'd2, 0, 4'h0, 4'd1, 1, 0, 0, 1, 32'h11111111, 1));
      q.push_back(mkx(1, 32'h40, 3'd2, 32'h22222222, 4'hF, 4'd2, 0, 0, 0, 0, 32'h0, 0));
      q.push_back(mkx(1, 32'h40, 3'd2, 32'h33333333, 4'hF, 4'd1, 1, 0, 0, 0, 32'h0, 0));
      q.push_back(rd_v(32'h40, 3'd2, 1'b0, 32'h22222222, 0));
      q.push_back(mkx(0, 32'h40, 3'd2, 0, 4'h0, 4'd1, 1, 0, 0, 1, 32'h22222222, 1));
      q.push_back(mkx(1, 32'h40, 3'd2, 32'h44444444, 4'hF, 4'd1, 1, 0, 0, 0, 32'h0, 1));
      q.push_back(rd_v(32'h40, 3'd2, 1'b0, 32'h44444444, 0));
      q.push_back(mkx(1, 32'h40, 3'd2, 32'h55555555, 4'hF, 4'd1, 1, 0, 0, 0, 32'h0, 0));
      q.push_back(rd_v(32'h40, 3'd2, 1'b0, 32'h44444444, 0));
`else
      q.push_back(mkx(0, 32'h40, 3'd2, 0, 4'h0, 4'd1, 1, 0, 0, 1, 32'h11111111, 0));
      q.push_back(mkx(1, 32'h40, 3'd2, 32'h33333333, 4'hF, 4'd1, 1, 0, 0, 0, 32'h0, 0));
      q.push_back(rd_v(32'h40, 3'd2, 1'b0, 32'h33333333, 0));
`endif
      run_q("excl");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
